// File: rtl/segment_display.sv
// segment_display: registered hex-to-seven-segment decoder with enable, blank, lamp test and polarity
module segment_display #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic en,
  input  logic blank,
  input  logic lamp_test,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);
  localparam logic [6:0] POL = {7{ACTIVE_LOW}};
  logic [6:0] glyph;
  logic [6:0] lit_next;
  logic [6:0] seg;
  // Glyph table, abcdefg with a lit segment as 1
  always_comb begin
    glyph = 7'b0000000;
    case ({x1, x2, x3, x4})
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1110011;
      4'ha: glyph = 7'b1110111;
      4'hb: glyph = 7'b0011111;
      4'hc: glyph = 7'b1001110;
      4'hd: glyph = 7'b0111101;
      4'he: glyph = 7'b1001111;
      4'hf: glyph = 7'b1000111;
      default: glyph = 7'b0000000;
    endcase
  end
  // Override priority: lamp test, then blank, then the decoded glyph
  always_comb begin
    lit_next = lamp_test ? 7'b1111111 : blank ? 7'b0000000 : glyph;
  end
  // Segment register holds the pad-polarity value so the outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg <= POL;
    else if (lamp_test || blank || en) seg <= lit_next ^ POL;
  end
  assign {a, b, c, d, e, f, g} = seg;
endmodule

// File: tb/tb_segment_display.sv
// tb_segment_display: directed checks of decode, hold, priority, async reset and inverted polarity
module tb_segment_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x1 = 1'b0, x2 = 1'b0, x3 = 1'b0, x4 = 1'b0;
  logic en = 1'b0, blank = 1'b0, lamp_test = 1'b0;
  logic ha, hb, hc, hd, he, hf, hg;
  logic la, lb, lc, ld, le, lf, lg;
  logic [6:0] seg_hi, seg_lo;
  logic [6:0] tbl [16];
  int checks = 0;
  int failures = 0;

  assign seg_hi = {ha, hb, hc, hd, he, hf, hg};
  assign seg_lo = {la, lb, lc, ld, le, lf, lg};

  always #5 clk = ~clk;

  segment_display #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .en(en), .blank(blank), .lamp_test(lamp_test),
    .a(ha), .b(hb), .c(hc), .d(hd), .e(he), .f(hf), .g(hg)
  );

  segment_display #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .en(en), .blank(blank), .lamp_test(lamp_test),
    .a(la), .b(lb), .c(lc), .d(ld), .e(le), .f(lf), .g(lg)
  );

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic set_code(input logic [3:0] v);
    {x1, x2, x3, x4} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      set_code(4'(i * 5 + 3));
      step();
      check("reset_hi", seg_hi, 7'b0000000);
      check("reset_lo", seg_lo, 7'b1111111);
    end
    rst_n = 1'b1;
    set_code(4'h0);
    step();
    check("first_hi", seg_hi, 7'b1111110);
    check("first_lo", seg_lo, 7'b0000001);
    for (int i = 0; i < 16; i++) begin
      set_code(4'(i));
      step();
      check($sformatf("decode_%0h", i), seg_hi, tbl[i]);
      check($sformatf("decode_lo_%0h", i), seg_lo, ~tbl[i]);
    end
    set_code(4'h2);
    step();
    check("hold_load", seg_hi, 7'b1101101);
    en = 1'b0;
    set_code(4'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold", seg_hi, 7'b1101101);
    end
    en = 1'b1;
    step();
    check("hold_release", seg_hi, 7'b1111111);
    set_code(4'h1);
    blank = 1'b1;
    lamp_test = 1'b1;
    step();
    check("lamp_over_blank", seg_hi, 7'b1111111);
    check("lamp_lo", seg_lo, 7'b0000000);
    lamp_test = 1'b0;
    step();
    check("blank", seg_hi, 7'b0000000);
    check("blank_lo", seg_lo, 7'b1111111);
    blank = 1'b0;
    step();
    check("unblank", seg_hi, 7'b0110000);
    en = 1'b0;
    blank = 1'b1;
    step();
    check("blank_no_en", seg_hi, 7'b0000000);
    blank = 1'b0;
    lamp_test = 1'b1;
    step();
    check("lamp_no_en", seg_hi, 7'b1111111);
    lamp_test = 1'b0;
    en = 1'b1;
    set_code(4'he);
    step();
    check("pre_async", seg_hi, 7'b1001111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_hi", seg_hi, 7'b0000000);
    check("async_lo", seg_lo, 7'b1111111);
    step();
    check("async_held", seg_hi, 7'b0000000);
    rst_n = 1'b1;
    step();
    check("recover_hi", seg_hi, 7'b1001111);
    check("recover_lo", seg_lo, 7'b0110000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/segment_display.md
Name: segment_display

Overview:
Registered hexadecimal-to-seven-segment decoder. Four input bits (x1 = MSB, x4 = LSB) select one of 16 glyphs (0-9, A, b, C, d, E, F), driving segments a-g. The block sits between the digit-value logic and the display pad drivers. It adds a clock-enable, blanking, lamp test and a polarity parameter, and registers the segment outputs.

Parameters:
ACTIVE_LOW, 0, 0 = a lit segment is driven as 1; 1 = every segment output is inverted at the register output (common-anode panels).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
x1  input  1  code bit 3 (MSB)
x2  input  1  code bit 2
x3  input  1  code bit 1
x4  input  1  code bit 0 (LSB)
en  input  1  update enable; when 0, outputs hold
blank  input  1  forces all segments dark
lamp_test  input  1  forces all segments lit
a  output  1  segment a (top)
b  output  1  segment b (top right)
c  output  1  segment c (bottom right)
d  output  1  segment d (bottom)
e  output  1  segment e (bottom left)
f  output  1  segment f (top left)
g  output  1  segment g (middle)

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). The single clock is clk.
- Reset: while rst_n = 0, all segments are dark. That means a..g = 0 when ACTIVE_LOW = 0, and all 1 when ACTIVE_LOW = 1. Reset takes effect immediately, without waiting for a clock edge. The first update occurs at the first rising clk edge after rst_n deasserts.
- Decode table, x1x2x3x4 -> abcdefg, lit = 1:
  - 0000 -> 1111110
  - 0001 -> 0110000
  - 0010 -> 1101101
  - 0011 -> 1111001
  - 0100 -> 0110011
  - 0101 -> 1011011
  - 0110 -> 1011111
  - 0111 -> 1110000
  - 1000 -> 1111111
  - 1001 -> 1110011 (nine without bottom segment)
  - 1010 -> 1110111
  - 1011 -> 0011111
  - 1100 -> 1001110
  - 1101 -> 0111101
  - 1110 -> 1001111
  - 1111 -> 1000111
- Next-value priority, evaluated each rising clk edge:
  1. lamp_test = 1: all seven segments lit. This ignores en.
  2. Otherwise, blank = 1: all seven segments dark. This ignores en.
  3. Otherwise, en = 1: the decoded pattern for the current x1..x4.
  4. Otherwise (en = 0): hold the previous register value.
- Latency: exactly 1 clk. The inputs sampled at edge N appear on a..g after edge N and remain stable until edge N+1.
- Polarity: ACTIVE_LOW inverts all seven outputs after the priority mux. This includes the lamp-test, blank and reset values.
- X/Z on x1..x4 is not required to propagate deterministically. The table is complete, so no default/illegal code exists.
- Outputs are driven only from flops, with no combinational input-to-output path.

Test Plan:
1. Reset: hold rst_n = 0, toggle inputs -> a..g = 0000000 throughout. Release, set en = 1, code 0000 -> 1111110 after the next edge.
2. Exhaustive decode: en = 1, step x1..x4 from 0000 to 1111, one per clock. Check each output one cycle later against the table, e.g. 0101 -> 1011011, 1001 -> 1110011, 1011 -> 0011111, 1111 -> 1000111.
3. Hold: load 0010 (1101101), then set en = 0 and apply 1000 for 3 cycles -> output stays 1101101. Set en = 1 -> 1111111 after the next edge.
4. Priority: code 0001 with blank = 1 and lamp_test = 1 -> 1111111. Drop lamp_test -> 0000000. Drop blank -> 0110000. With en = 0 and blank = 1 -> 0000000.
5. Async reset mid-operation: while displaying 1110 (1001111), pull rst_n low between clock edges -> outputs go to 0000000 before the next edge. They recover one edge after release.
6. ACTIVE_LOW = 1 instance: code 0000 -> 0000001; reset -> 1111111; lamp_test -> 0000000.
